// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: drives one external 1-bit ALU slice for WIDTH cycles, LSB first, to build a
// full-width AND/OR/NOR/ADD/SUB/SLT result.  Operands are captured on an accepted start, and
// the carry is fed back from slice_cout_i to slice_cin_o between cycles.  Result and flags are
// registered on entry to DONE and hold until the next operation completes.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-low reset
//   start_i, ctrl_i      request and ALU control (accepted only when idle)
//   src1_i, src2_i       operands
//   abort_i              (only with ALU_SERIAL_ABORT_EN) cancel a running operation
//   busy_o, done_o       running / one-cycle completion pulse
//   result_o, zero_o     registered result and its zero flag
//   cout_o, overflow_o   MSB carry-out / signed overflow (ADD and SUB only)
//   slice_*_o            per-cycle controls and operand bits to the 1-bit slice
//   slice_*_i            combinational outputs of the slice
//
// Optional feature macro: ALU_SERIAL_ABORT_EN adds the abort_i port.

module alu_serial_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [3:0]       ctrl_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
`ifdef ALU_SERIAL_ABORT_EN
   input  logic             abort_i,
`endif
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             cout_o,
   output logic             overflow_o,
   output logic             slice_src1_o,
   output logic             slice_src2_o,
   output logic             slice_less_o,
   output logic             slice_a_inv_o,
   output logic             slice_b_inv_o,
   output logic             slice_cin_o,
   output logic [1:0]       slice_op_o,
   input  logic             slice_result_i,
   input  logic             slice_cout_i,
   input  logic             slice_overflow_i,
   input  logic             slice_set_i
);

   localparam int unsigned     IdxW    = $clog2(WIDTH);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

   localparam logic [3:0] CtrlAnd = 4'b0000;
   localparam logic [3:0] CtrlOr  = 4'b0001;
   localparam logic [3:0] CtrlAdd = 4'b0010;
   localparam logic [3:0] CtrlSub = 4'b0110;
   localparam logic [3:0] CtrlSlt = 4'b0111;
   localparam logic [3:0] CtrlNor = 4'b1100;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StRun    = 2'd1;
   localparam logic [1:0] StSltFix = 2'd2;
   localparam logic [1:0] StDone   = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [IdxW-1:0]  idx_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q, b_q;     // shifted right each RUN cycle so bit 0 is the current bit
   logic [WIDTH-1:0] acc_q;        // result bits shift in from the top, LSB first
   logic [3:0]       ctrl_q;
   logic             lt_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q, cout_q, ovf_q;

   logic             abort_req;
   logic             start_legal, start_cin;
   logic [1:0]       run_op;
   logic             run_a_inv, run_b_inv, run_arith;
   logic             last_bit;
   logic [WIDTH-1:0] acc_next;

`ifdef ALU_SERIAL_ABORT_EN
   assign abort_req = abort_i;
`else
   assign abort_req = 1'b0;
`endif

   assign last_bit = (idx_q == LastIdx);
   assign acc_next = {slice_result_i, acc_q[WIDTH-1:1]};

   // Decode of the incoming request.
   always_comb begin
      start_legal = 1'b0;
      start_cin   = 1'b0;
      case (ctrl_i)
         CtrlAnd, CtrlOr, CtrlAdd, CtrlNor: start_legal = 1'b1;
         CtrlSub, CtrlSlt: begin
            start_legal = 1'b1;
            start_cin   = 1'b1;
         end
         default: ;
      endcase
   end

   // Slice controls for the latched operation; constant across RUN.
   always_comb begin
      run_op    = 2'b00;
      run_a_inv = 1'b0;
      run_b_inv = 1'b0;
      run_arith = 1'b0;
      case (ctrl_q)
         CtrlOr: run_op = 2'b01;
         CtrlNor: begin
            run_a_inv = 1'b1;
            run_b_inv = 1'b1;
         end
         CtrlAdd: begin
            run_op    = 2'b10;
            run_arith = 1'b1;
         end
         CtrlSub: begin
            run_op    = 2'b10;
            run_b_inv = 1'b1;
            run_arith = 1'b1;
         end
         CtrlSlt: begin
            run_op    = 2'b10;
            run_b_inv = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (start_i) state_d = start_legal ? StRun : StDone;
         end
         StRun: begin
            if (abort_req)     state_d = StIdle;
            else if (last_bit) state_d = (ctrl_q == CtrlSlt) ? StSltFix : StDone;
         end
         StSltFix: state_d = abort_req ? StIdle : StDone;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      slice_src1_o  = 1'b0;
      slice_src2_o  = 1'b0;
      slice_less_o  = 1'b0;
      slice_a_inv_o = 1'b0;
      slice_b_inv_o = 1'b0;
      slice_cin_o   = 1'b0;
      slice_op_o    = 2'b00;
      case (state_q)
         StRun: begin
            slice_src1_o  = a_q[0];
            slice_src2_o  = b_q[0];
            slice_cin_o   = carry_q;
            slice_op_o    = run_op;
            slice_a_inv_o = run_a_inv;
            slice_b_inv_o = run_b_inv;
         end
         StSltFix: begin
            slice_op_o   = 2'b11;
            slice_less_o = lt_q;
         end
         default: ;
      endcase
   end

   assign busy_o     = (state_q == StRun) || (state_q == StSltFix);
   assign done_o     = (state_q == StDone);
   assign result_o   = result_q;
   assign zero_o     = zero_q;
   assign cout_o     = cout_q;
   assign overflow_o = ovf_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         ctrl_q   <= '0;
         lt_q     <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            StIdle: begin
               if (start_i && start_legal) begin
                  a_q     <= src1_i;
                  b_q     <= src2_i;
                  ctrl_q  <= ctrl_i;
                  idx_q   <= '0;
                  carry_q <= start_cin;
                  acc_q   <= '0;
               end else if (start_i) begin
                  result_q <= '0;
                  zero_q   <= 1'b1;
                  cout_q   <= 1'b0;
                  ovf_q    <= 1'b0;
               end
            end
            StRun: begin
               if (abort_req) begin
                  idx_q   <= '0;
                  carry_q <= 1'b0;
               end else begin
                  a_q     <= a_q >> 1;
                  b_q     <= b_q >> 1;
                  acc_q   <= acc_next;
                  carry_q <= slice_cout_i;
                  idx_q   <= idx_q + IdxW'(1);
                  if (last_bit) begin
                     idx_q <= '0;
                     // Signed less-than: sign of A-B corrected by overflow.
                     lt_q  <= slice_set_i ^ slice_overflow_i;
                     if (ctrl_q != CtrlSlt) begin
                        result_q <= acc_next;
                        zero_q   <= (acc_next == '0);
                        cout_q   <= run_arith & slice_cout_i;
                        ovf_q    <= run_arith & slice_overflow_i;
                     end
                  end
               end
            end
            StSltFix: begin
               if (abort_req) begin
                  idx_q   <= '0;
                  carry_q <= 1'b0;
               end else begin
                  result_q <= {{(WIDTH - 1){1'b0}}, slice_result_i};
                  zero_q   <= ~slice_result_i;
                  cout_q   <= 1'b0;
                  ovf_q    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl at WIDTH=32 with a behavioural 1-bit slice attached.  Directed
// vectors come from a table; random operations are checked against a word-level model.
// Latency is counted in clock edges after the accept edge until done_o is seen.

module tb_alu_serial_ctrl;

   localparam int W = 32;

   localparam logic [3:0] OpAnd = 4'b0000;
   localparam logic [3:0] OpOr  = 4'b0001;
   localparam logic [3:0] OpAdd = 4'b0010;
   localparam logic [3:0] OpSub = 4'b0110;
   localparam logic [3:0] OpSlt = 4'b0111;
   localparam logic [3:0] OpNor = 4'b1100;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [3:0]   ctrl;
   logic [W-1:0] src1, src2;
`ifdef ALU_SERIAL_ABORT_EN
   logic         abort;
`endif
   logic         busy, done, zero, cout, ovf;
   logic [W-1:0] result;
   logic         s_src1, s_src2, s_less, s_ainv, s_binv, s_cin;
   logic [1:0]   s_op;
   logic         s_result, s_cout, s_ovf, s_set;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_serial_ctrl #(.WIDTH(W)) dut (
      .clk_i           (clk),
      .rst_i           (rst_n),
      .start_i         (start),
      .ctrl_i          (ctrl),
      .src1_i          (src1),
      .src2_i          (src2),
`ifdef ALU_SERIAL_ABORT_EN
      .abort_i         (abort),
`endif
      .busy_o          (busy),
      .done_o          (done),
      .result_o        (result),
      .zero_o          (zero),
      .cout_o          (cout),
      .overflow_o      (ovf),
      .slice_src1_o    (s_src1),
      .slice_src2_o    (s_src2),
      .slice_less_o    (s_less),
      .slice_a_inv_o   (s_ainv),
      .slice_b_inv_o   (s_binv),
      .slice_cin_o     (s_cin),
      .slice_op_o      (s_op),
      .slice_result_i  (s_result),
      .slice_cout_i    (s_cout),
      .slice_overflow_i(s_ovf),
      .slice_set_i     (s_set)
   );

   // Behavioural 1-bit ALU slice.
   logic sa, sb, ssum, sco;
   always_comb begin
      sa   = s_src1 ^ s_ainv;
      sb   = s_src2 ^ s_binv;
      ssum = sa ^ sb ^ s_cin;
      sco  = (sa & sb) | (sa & s_cin) | (sb & s_cin);
      case (s_op)
         2'b00:   s_result = sa & sb;
         2'b01:   s_result = sa | sb;
         2'b10:   s_result = ssum;
         default: s_result = s_less;
      endcase
      s_cout = sco;
      s_ovf  = sco ^ s_cin;
      s_set  = ssum;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Word-level reference: result, carry, overflow, latency and busy cycles.
   task automatic ref_alu(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic co, output logic v,
                          output int lat, output int bsy);
      logic [W:0] s;
      r = '0; co = 1'b0; v = 1'b0; lat = W; bsy = W;
      case (c)
         OpAnd: r = a & b;
         OpOr:  r = a | b;
         OpNor: r = ~(a | b);
         OpAdd: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[W-1:0]; co = s[W];
            v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         OpSub: begin
            s = {1'b0, a} + {1'b0, ~b} + 1;
            r = s[W-1:0]; co = s[W];
            v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         OpSlt: begin
            r = ($signed(a) < $signed(b)) ? 1 : 0;
            lat = W + 1; bsy = W + 1;
         end
         default: begin
            lat = 0; bsy = 0;
         end
      endcase
   endtask

   // Issue one request, wait (bounded) for done_o, then step back into IDLE.
   task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit interfere, output int lat, output int bsy, output bit got);
      @(negedge clk);
      start = 1'b1; ctrl = c; src1 = a; src2 = b;
      @(posedge clk); #1;
      start = 1'b0; ctrl = 4'($urandom); src1 = $urandom; src2 = $urandom;
      lat = 0; bsy = 0; got = 1'b0;
      while (!got && lat < 100) begin
         if (done) got = 1'b1;
         else begin
            if (busy) bsy++;
            start = interfere && (lat == 5);
            if (interfere) ctrl = OpSub;
            @(posedge clk); #1;
            lat++;
         end
      end
      start = 1'b0;
      if (!got) $display("FAIL timeout: done_o not seen within %0d cycles", lat);
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
   endtask

   typedef struct {
      logic [3:0]   c;
      logic [W-1:0] a, b, r;
      logic         z, co, v;
      int           lat, bsy;
   } vec_t;

   vec_t       vecs[12];
   logic [3:0] ops[6];

   initial begin
      int lat, bsy, cnt;
      bit got;
      logic [W-1:0] a, b, er;
      logic eco, ev;
      int elat, ebsy;
      logic [3:0] c;

      ops = '{OpAnd, OpOr, OpAdd, OpSub, OpSlt, OpNor};
      vecs[0]  = '{OpAdd, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, W,     W};
      vecs[1]  = '{OpSub, 32'd5,        32'd5,        32'h00000000, 1'b1, 1'b1, 1'b0, W,     W};
      vecs[2]  = '{OpSlt, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, W + 1, W + 1};
      vecs[3]  = '{OpSlt, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, W + 1, W + 1};
      vecs[4]  = '{OpSlt, 32'd3,        32'd2,        32'h00000000, 1'b1, 1'b0, 1'b0, W + 1, W + 1};
      vecs[5]  = '{OpNor, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 1'b0, 1'b0, 1'b0, W,     W};
      vecs[6]  = '{OpOr,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0, 1'b0, W,     W};
      vecs[7]  = '{OpAnd, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000000, 1'b1, 1'b0, 1'b0, W,     W};
      // Illegal code: DONE on the cycle right after the start cycle.
      vecs[8]  = '{4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b0, 0,  0};
      vecs[9]  = '{OpSub, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, W,     W};
      vecs[10] = '{OpSub, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, W,     W};
      vecs[11] = '{OpAdd, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, W,     W};

      rst_n = 1'b0; start = 1'b0; ctrl = '0; src1 = '0; src2 = '0;
`ifdef ALU_SERIAL_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_result", result, 0);
      chk("rst_flags", {busy, done, zero, cout, ovf}, 0);
      chk("rst_slice", {s_src1, s_src2, s_less, s_ainv, s_binv, s_cin, s_op}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_op(vecs[i].c, vecs[i].a, vecs[i].b, 1'b0, lat, bsy, got);
         chk($sformatf("vec%0d_done", i), got, 1);
         chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
         chk($sformatf("vec%0d_busy", i), bsy, vecs[i].bsy);
         chk($sformatf("vec%0d_result", i), result, vecs[i].r);
         chk($sformatf("vec%0d_flags", i), {zero, cout, ovf}, {vecs[i].z, vecs[i].co, vecs[i].v});
      end
      chk("idle_slice", {s_src1, s_src2, s_less, s_ainv, s_binv, s_cin, s_op}, 0);

      // Randomized operations against the model.
      for (int i = 0; i < 40; i++) begin
         int k;
         k = $urandom_range(0, 6);
         c = (k == 6) ? 4'($urandom) : ops[k];
         a = $urandom;
         b = (i % 5 == 0) ? a : $urandom;
         ref_alu(c, a, b, er, eco, ev, elat, ebsy);
         run_op(c, a, b, 1'b0, lat, bsy, got);
         chk($sformatf("rnd%0d_c%0h_lat", i, c), lat, elat);
         chk($sformatf("rnd%0d_c%0h_result", i, c), result, er);
         chk($sformatf("rnd%0d_c%0h_flags", i, c), {zero, cout, ovf}, {er == 0, eco, ev});
      end

      // Second start during RUN is ignored.
      run_op(OpAdd, 32'h12345678, 32'h11111111, 1'b1, lat, bsy, got);
      chk("ignore_lat", lat, W);
      chk("ignore_result", result, 32'h23456789);
      cnt = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) cnt++;
      end
      chk("ignore_no_second_op", cnt, 0);

`ifdef ALU_SERIAL_ABORT_EN
      // Abort at cycle 10 keeps the previous result and produces no done.
      run_op(OpOr, 32'hF0F0F0F0, 32'h0F0F0000, 1'b0, lat, bsy, got);
      @(negedge clk);
      start = 1'b1; ctrl = OpAdd; src1 = 32'h1; src2 = 32'h2;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_result_kept", result, 32'hFFFFF0F0);
      cnt = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) cnt++;
      end
      chk("abort_no_done", cnt, 0);
      run_op(OpAdd, 32'd7, 32'd8, 1'b0, lat, bsy, got);
      chk("abort_then_add", result, 32'd15);
`endif

      // Asynchronous reset at cycle 10 of an ADD.
      @(negedge clk);
      start = 1'b1; ctrl = OpAdd; src1 = 32'h0000FFFF; src2 = 32'h00000001;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_result", result, 0);
      chk("midrst_flags", {busy, done, zero, cout, ovf}, 0);
      chk("midrst_slice", {s_src1, s_src2, s_less, s_ainv, s_binv, s_cin, s_op}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) cnt++;
      end
      chk("midrst_no_done", cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
